mips_rtype_issue: RTL and testbench

MIPS_RTYPE_ISSUE -- requirements
Module: mips_rtype_issue

---
 rtl/mips_rtype_issue.sv | 170 +++++++++++++++++
 tb/tb_mips_rtype_issue.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_rtype_issue.sv
// Multi-cycle issue stage for MIPS R-type ALU instructions: decodes, reads a 32x32 register
// file, drives an external ALU and writes the result back. Includes a debug register port.
module mips_rtype_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [3:0]  alu_ctl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        done,
    output logic [31:0] result,
    output logic        zero,
    output logic        illegal,
    input  logic        dbg_we,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_data
);

    typedef enum logic [2:0] {StIdle, StDecode, StExec, StWb, StErr} state_e;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [3:0]  alu_ctl_q, alu_ctl_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [31:0] hold_res_q, hold_res_d;
    logic        hold_zero_q, hold_zero_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
    logic [31:0] rf_q [32];

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_val, rt_val;
    logic        dec_legal;
    logic [3:0]  dec_ctl;
    logic        unused_shamt;

    assign op     = instr_q[31:26];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];
    assign funct  = instr_q[5:0];
    assign unused_shamt = ^instr_q[10:6];

    assign rs_val = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 : rf_q[rt];

    always_comb begin
        dec_legal = (op == 6'd0);
        dec_ctl   = 4'd0;
        case (funct)
            6'd32:   dec_ctl = 4'd2;
            6'd34:   dec_ctl = 4'd6;
            6'd36:   dec_ctl = 4'd0;
            6'd37:   dec_ctl = 4'd1;
            6'd39:   dec_ctl = 4'd12;
            6'd42:   dec_ctl = 4'd7;
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        alu_ctl_d   = alu_ctl_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        hold_res_d  = hold_res_q;
        hold_zero_d = hold_zero_q;
        result_d    = result_q;
        zero_d      = zero_q;
        done_d      = 1'b0;
        illegal_d   = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = dbg_addr;
        rf_wdata    = dbg_wdata;
        unique case (state_q)
            StIdle: begin
                // Debug writes land at the same edge an instruction is accepted.
                rf_we = dbg_we && (dbg_addr != 5'd0);
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (dec_legal) begin
                    alu_ctl_d = dec_ctl;
                    alu_a_d   = rs_val;
                    alu_b_d   = rt_val;
                    state_d   = StExec;
                end else begin
                    state_d   = StErr;
                end
            end
            StExec: begin
                hold_res_d  = alu_out;
                hold_zero_d = alu_zero;
                state_d     = StWb;
            end
            StWb: begin
                rf_we    = (rd != 5'd0);
                rf_waddr = rd;
                rf_wdata = hold_res_q;
                result_d = hold_res_q;
                zero_d   = hold_zero_q;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            StErr: begin
                illegal_d = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            instr_q     <= 32'd0;
            alu_ctl_q   <= 4'd0;
            alu_a_q     <= 32'd0;
            alu_b_q     <= 32'd0;
            hold_res_q  <= 32'd0;
            hold_zero_q <= 1'b0;
            result_q    <= 32'd0;
            zero_q      <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            alu_ctl_q   <= alu_ctl_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            hold_res_q  <= hold_res_d;
            hold_zero_q <= hold_zero_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
            if (rf_we) rf_q[rf_waddr] <= rf_wdata;
        end
    end

    assign instr_ready = (state_q == StIdle);
    assign alu_ctl     = alu_ctl_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign result      = result_q;
    assign zero        = zero_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign dbg_data    = (dbg_addr == 5'd0) ? 32'd0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_mips_rtype_issue.sv
// Bench for mips_rtype_issue: external ALU model, transaction-level reference model,
// per-cycle output compare, directed scenarios and randomized traffic.
module tb_mips_rtype_issue;

    logic        clk = 1'b0;
    logic        reset, instr_valid, instr_ready, alu_zero, done, zero, illegal, dbg_we;
    logic [31:0] instr, alu_a, alu_b, alu_out, result, dbg_wdata, dbg_data;
    logic [3:0]  alu_ctl;
    logic [4:0]  dbg_addr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mips_rtype_issue dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_ctl     (alu_ctl),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .done        (done),
        .result      (result),
        .zero        (zero),
        .illegal     (illegal),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_data    (dbg_data)
    );

    // External combinational ALU
    always_comb begin
        alu_out = 32'd0;
        case (alu_ctl)
            4'd2:    alu_out = alu_a + alu_b;
            4'd6:    alu_out = alu_a - alu_b;
            4'd0:    alu_out = alu_a & alu_b;
            4'd1:    alu_out = alu_a | alu_b;
            4'd12:   alu_out = ~(alu_a | alu_b);
            4'd7:    alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_out = 32'd0;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got=0x%08h expected=0x%08h", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model (transaction age, not RTL states) ----------------
    int          m_age = 0;   // edges since acceptance; 0 means ready for a new word
    logic [31:0] m_ins;
    logic [31:0] m_rf [32];
    logic [3:0]  m_ctl;
    logic [31:0] m_a, m_b, m_result;
    logic        m_zero, m_done, m_ill;

    function automatic int exp_ctl(input logic [31:0] w);
        if (w[31:26] != 6'd0) return -1;
        case (w[5:0])
            6'd32:   return 2;
            6'd34:   return 6;
            6'd36:   return 0;
            6'd37:   return 1;
            6'd39:   return 12;
            6'd42:   return 7;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] f_alu(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        case (f)
            6'd32:   return a + b;
            6'd34:   return a - b;
            6'd36:   return a & b;
            6'd37:   return a | b;
            6'd39:   return ~(a | b);
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] r;
        int          c;
        m_done = 1'b0;
        m_ill  = 1'b0;
        if (reset) begin
            m_age = 0;
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_ctl = 4'd0; m_a = 32'd0; m_b = 32'd0; m_result = 32'd0; m_zero = 1'b0;
            return;
        end
        c = exp_ctl(m_ins);
        case (m_age)
            0: begin
                if (dbg_we && dbg_addr != 5'd0) m_rf[dbg_addr] = dbg_wdata;
                if (instr_valid) begin
                    m_ins = instr;
                    m_age = 1;
                end
            end
            1: begin
                if (c >= 0) begin
                    m_ctl = 4'(c);
                    m_a   = m_rf[m_ins[25:21]];
                    m_b   = m_rf[m_ins[20:16]];
                end
                m_age = 2;
            end
            2: begin
                if (c >= 0) m_age = 3;
                else begin
                    m_ill = 1'b1;
                    m_age = 0;
                end
            end
            default: begin
                r = f_alu(m_ins[5:0], m_a, m_b);
                if (m_ins[15:11] != 5'd0) m_rf[m_ins[15:11]] = r;
                m_result = r;
                m_zero   = (r == 32'd0);
                m_done   = 1'b1;
                m_age    = 0;
            end
        endcase
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_ins = 32'd0;
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    // Per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("ready",   32'(instr_ready), 32'(m_age == 0));
            chk("done",    32'(done),        32'(m_done));
            chk("illegal", 32'(illegal),     32'(m_ill));
            chk("excl",    32'(done & illegal), 32'd0);
            chk("result",  result,           m_result);
            chk("zero",    32'(zero),        32'(m_zero));
            chk("alu_ctl", 32'(alu_ctl),     32'(m_ctl));
            chk("alu_a",   alu_a,            m_a);
            chk("alu_b",   alu_b,            m_b);
            chk("dbg",     dbg_data,         (dbg_addr == 5'd0) ? 32'd0 : m_rf[dbg_addr]);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed helpers ----------------
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
        @(posedge clk); #1;
        dbg_we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        @(negedge clk); #2;
        dbg_addr = a;
        #1 v = dbg_data;
    endtask

    task automatic issue(input logic [31:0] w, output int e0);
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) chk("ready_wait", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1; instr = w;
        @(posedge clk); #1;
        e0 = cyc;
        instr_valid = 1'b0;
    endtask

    // Issues w and stops at the negedge of the done/illegal cycle.
    task automatic run(input logic [31:0] w, output int e0, output int lat,
                       output logic [3:0] ctl, output logic [31:0] a, output logic [31:0] b);
        issue(w, e0);
        lat = 0; ctl = 4'd0; a = 32'd0; b = 32'd0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 2) begin ctl = alu_ctl; a = alu_a; b = alu_b; end
            if (done || illegal) begin lat = i; break; end
        end
        if (lat == 0) chk("completion_timeout", 32'd0, 32'd1);
    endtask

    logic [31:0] v, sa, sb;
    logic [3:0]  sc;
    int          e0, e1, lat;

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = 32'd0;
        dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;
        @(posedge clk); #1 chk_en = 1'b1;
        @(posedge clk); #1 reset = 1'b0;

        // Reset state and r0 behaviour
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_result", result, 32'd0);
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), v);
            chk("rst_rf", v, 32'd0);
        end
        wr(5'd0, 32'hFFFF_FFFF);
        rd(5'd0, v);
        chk("r0_write", v, 32'd0);

        // add r3,r1,r2
        wr(5'd1, 32'd5);
        wr(5'd2, 32'd3);
        run(32'h0022_1820, e0, lat, sc, sa, sb);
        chk("add_ctl", 32'(sc), 32'd2);
        chk("add_a", sa, 32'd5);
        chk("add_b", sb, 32'd3);
        chk("add_lat", 32'(lat), 32'd4);
        chk("add_done", 32'(done), 32'd1);
        chk("add_res", result, 32'd8);
        chk("add_zero", 32'(zero), 32'd0);
        rd(5'd3, v);
        chk("add_r3", v, 32'd8);

        // sub r4,r1,r1 then slt r5,r2,r1
        run(32'h0021_2022, e0, lat, sc, sa, sb);
        chk("sub_ctl", 32'(sc), 32'd6);
        chk("sub_res", result, 32'd0);
        chk("sub_zero", 32'(zero), 32'd1);
        rd(5'd4, v);
        chk("sub_r4", v, 32'd0);
        run(32'h0041_282A, e0, lat, sc, sa, sb);
        chk("slt_ctl", 32'(sc), 32'd7);
        rd(5'd5, v);
        chk("slt_r5", v, 32'd1);

        // Illegal words: funct 0, then op 8 accepted in the illegal cycle
        run(32'h0022_1800, e0, lat, sc, sa, sb);
        chk("ill1_lat", 32'(lat), 32'd3);
        chk("ill1_pulse", 32'(illegal), 32'd1);
        chk("ill1_done", 32'(done), 32'd0);
        run(32'h2022_1820, e1, lat, sc, sa, sb);
        chk("ill_ii", 32'(e1 - e0), 32'd3);
        chk("ill2_pulse", 32'(illegal), 32'd1);
        chk("ill_ctl_kept", 32'(alu_ctl), 32'd7);
        chk("ill_a_kept", alu_a, 32'd3);
        chk("ill_b_kept", alu_b, 32'd5);
        chk("ill_res_kept", result, 32'd1);
        rd(5'd3, v);
        chk("ill_r3", v, 32'd8);

        // rd=0 add, then back-to-back accept in the done cycle
        run(32'h0022_0020, e0, lat, sc, sa, sb);
        chk("rd0_done", 32'(done), 32'd1);
        chk("rd0_res", result, 32'd8);
        run(32'h0021_2022, e1, lat, sc, sa, sb);
        chk("legal_ii", 32'(e1 - e0), 32'd4);
        rd(5'd0, v);
        chk("rd0_r0", v, 32'd0);

        // Debug write coinciding with acceptance: add r7,r6,r0 sees new r6
        @(negedge clk);
        dbg_we = 1'b1; dbg_addr = 5'd6; dbg_wdata = 32'd77;
        instr_valid = 1'b1; instr = 32'h00C0_3820;
        @(posedge clk); #1;
        dbg_we = 1'b0; instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("e0wr_done", 32'(done), 32'd1);
        chk("e0wr_res", result, 32'd77);

        // Reset while in EXEC
        issue(32'h0022_1820, e0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rstx_ready", 32'(instr_ready), 32'd1);
        chk("rstx_done", 32'(done), 32'd0);
        chk("rstx_a", alu_a, 32'd0);
        @(negedge clk);
        chk("rstx_done2", 32'(done), 32'd0);
        chk("rstx_res", result, 32'd0);
        rd(5'd3, v);
        chk("rstx_r3", v, 32'd0);

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            reset       = ($urandom_range(0, 199) == 0);
            instr_valid = ($urandom_range(0, 2) == 0);
            instr       = {($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0,
                           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                           5'($urandom_range(0, 7)), 5'($urandom),
                           ($urandom_range(0, 6) == 0) ? 6'($urandom) :
                           6'(exp_pick($urandom_range(0, 5)))};
            dbg_we      = ($urandom_range(0, 3) == 0);
            dbg_addr    = 5'($urandom_range(0, 9));
            dbg_wdata   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
        end
        @(posedge clk); #1;
        reset = 1'b0; instr_valid = 1'b0; dbg_we = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic int exp_pick(input int unsigned i);
        case (i)
            0:       return 32;
            1:       return 34;
            2:       return 36;
            3:       return 37;
            4:       return 39;
            default: return 42;
        endcase
    endfunction

endmodule
